// File: rtl/obi_arb_pkg.sv
// Shared constants and types for the three-requester OBI RAM arbiter.
package obi_arb_pkg;

  localparam int NUM_REQ    = 3;
  localparam int REQ_LOADER = 0;
  localparam int REQ_DATA   = 1;
  localparam int REQ_INSTR  = 2;

  typedef logic [1:0] req_idx_t;

  // Attributes of one requester's access, as presented on its port
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

endpackage

// File: rtl/obi_rr_arb2.sv
// Two-input round-robin arbiter used for the core data and instruction ports.
// gnt_o is combinational; the preference bit flips to the other input after
// each grant so neither port can starve the other.
module obi_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // 0: input 0 wins a tie, 1: input 1 wins a tie
  logic r_rr;

  // Pick a winner; on a tie the preference bit decides
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_i == 2'b11) begin
        gnt_o = r_rr ? 2'b10 : 2'b01;
      end else begin
        gnt_o = req_i;
      end
    end
  end

  // Hand preference to the other input after every grant
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr <= 1'b0;
    end else if (gnt_o[0]) begin
      r_rr <= 1'b1;
    end else if (gnt_o[1]) begin
      r_rr <= 1'b0;
    end
  end

endmodule

// File: rtl/obi_ram_arbiter.sv
// Shares one single-port word-addressed RAM between the firmware loader
// (fixed top priority) and the core data/instruction ports (round robin).
// Out-of-range accesses are granted but never reach the RAM; they are
// answered locally with err=1 one cycle later.
module obi_ram_arbiter
  import obi_arb_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 22,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NUM_REQ-1:0]                     req_i,
  input  logic [NUM_REQ-1:0][31:0]               addr_i,
  input  logic [NUM_REQ-1:0]                     we_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH/8-1:0]   be_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     wdata_i,
  output logic [NUM_REQ-1:0]                     gnt_o,
  output logic [NUM_REQ-1:0]                     rvalid_o,
  output logic [NUM_REQ-1:0]                     err_o,
  output logic [DATA_WIDTH-1:0]                  rdata_o,
  output logic                                   ram_en_o,
  output logic                                   ram_we_o,
  output logic [RAM_ADDR_WIDTH-3:0]              ram_addr_o,
  output logic [DATA_WIDTH/8-1:0]                ram_be_o,
  output logic [DATA_WIDTH-1:0]                  ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]                  ram_rdata_i
);

  obi_req_t           w_reqs [NUM_REQ];
  obi_req_t           w_sel;
  logic [1:0]         w_rr_gnt;
  logic [NUM_REQ-1:0] w_gnt;
  req_idx_t           w_idx;
  logic               w_any;
  logic               w_in_range;

  // Response state for the access granted in the previous cycle
  logic [NUM_REQ-1:0] r_rvalid;
  logic               r_err;
  logic               r_rd;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_pack
      assign w_reqs[gi] = '{addr: addr_i[gi], we: we_i[gi], be: be_i[gi], wdata: wdata_i[gi]};
    end
  endgenerate

  // Core ports only compete when the loader is idle and reset is low
  obi_rr_arb2 u_rr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (~req_i[REQ_LOADER] & ~rst_i),
    .req_i (req_i[REQ_INSTR:REQ_DATA]),
    .gnt_o (w_rr_gnt)
  );

  // Loader first, otherwise the round-robin result
  always_comb begin
    w_gnt = '0;
    w_idx = req_idx_t'(REQ_LOADER);
    if (!rst_i) begin
      if (req_i[REQ_LOADER]) begin
        w_gnt = 3'b001;
      end else begin
        w_gnt = {w_rr_gnt, 1'b0};
      end
    end
    if (w_gnt[REQ_DATA])  w_idx = req_idx_t'(REQ_DATA);
    if (w_gnt[REQ_INSTR]) w_idx = req_idx_t'(REQ_INSTR);
  end

  // Select the winner's attributes and check its address range
  always_comb begin
    case (w_idx)
      req_idx_t'(REQ_DATA):  w_sel = w_reqs[REQ_DATA];
      req_idx_t'(REQ_INSTR): w_sel = w_reqs[REQ_INSTR];
      default:               w_sel = w_reqs[REQ_LOADER];
    endcase
    w_any      = |w_gnt;
    w_in_range = (w_sel.addr >> RAM_ADDR_WIDTH) == 32'd0;
  end

  // Drive the RAM from the winner; all-zero when nothing is granted
  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_be_o    = '0;
    ram_wdata_o = '0;
    if (w_any) begin
      ram_en_o    = w_in_range;
      ram_we_o    = w_sel.we;
      ram_addr_o  = w_sel.addr[RAM_ADDR_WIDTH-1:2];
      ram_be_o    = w_sel.be;
      ram_wdata_o = w_sel.wdata;
    end
  end

  // Remember who was granted and what kind of response it needs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rvalid <= '0;
      r_err    <= 1'b0;
      r_rd     <= 1'b0;
    end else begin
      r_rvalid <= w_gnt;
      r_err    <= w_any & ~w_in_range;
      r_rd     <= w_any & w_in_range & ~w_sel.we;
    end
  end

  // Responses are suppressed while reset is held so a pending one is dropped
  always_comb begin
    gnt_o    = w_gnt;
    rvalid_o = rst_i ? '0 : r_rvalid;
    err_o    = (rst_i || !r_err) ? '0 : r_rvalid;
    rdata_o  = (rst_i || !r_rd) ? '0 : ram_rdata_i;
  end

endmodule

// File: tb/tb_obi_ram_arbiter.sv
// Self-checking bench for obi_ram_arbiter: directed scenarios plus a
// randomized run, all compared against a transaction-level reference model.
module tb_obi_ram_arbiter;

  localparam int AW = 22;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        req;
  logic [2:0][31:0]  addr;
  logic [2:0]        we;
  logic [2:0][3:0]   be;
  logic [2:0][31:0]  wdata;
  logic [2:0]        gnt_o, rvalid_o, err_o;
  logic [31:0]       rdata_o;
  logic              ram_en, ram_we;
  logic [AW-3:0]     ram_addr;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata = 32'd0;

  int n_checks = 0;
  int n_fail   = 0;

  obi_ram_arbiter #(.RAM_ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .err_o(err_o), .rdata_o(rdata_o),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_be_o(ram_be),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM macro: byte-enabled write, registered read, plus a preload port
  logic [31:0]   ram_mem [0:(1<<(AW-2))-1];
  logic          pl_en = 1'b0;
  logic [AW-3:0] pl_addr = '0;
  logic [31:0]   pl_data = '0;
  always @(posedge clk) begin
    if (pl_en) begin
      ram_mem[pl_addr] <= pl_data;
    end else if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= ram_mem[ram_addr];
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [int];
  int          m_last_core;   // last core port served: 1 data, 2 instr, 0 none since reset
  bit          m_pv;
  int          m_pidx;
  bit          m_perr;
  logic [31:0] m_prdata;

  int          e_win;
  logic [2:0]  e_gnt, e_rvalid, e_err;
  logic        e_ram_en, e_ram_we;
  logic [AW-3:0] e_ram_addr;
  logic [3:0]  e_ram_be;
  logic [31:0] e_ram_wdata, e_rdata;

  function automatic logic [31:0] ref_rd(int w);
    return ref_mem.exists(w) ? ref_mem[w] : 32'd0;
  endfunction

  task automatic compute_exp();
    logic [31:0] a;
    e_win = -1;
    if (!rst) begin
      if (req[0])                 e_win = 0;
      else if (req[1] && req[2])  e_win = (m_last_core == 1) ? 2 : 1;
      else if (req[1])            e_win = 1;
      else if (req[2])            e_win = 2;
    end
    e_gnt = '0; e_ram_en = 0; e_ram_we = 0; e_ram_addr = '0; e_ram_be = '0; e_ram_wdata = '0;
    if (e_win >= 0) begin
      a           = addr[e_win];
      e_gnt[e_win] = 1'b1;
      e_ram_en    = (a < (32'd1 << AW));
      e_ram_addr  = a[AW-1:2];
      e_ram_we    = we[e_win];
      e_ram_be    = be[e_win];
      e_ram_wdata = wdata[e_win];
    end
    e_rvalid = (!rst && m_pv) ? 3'(1 << m_pidx) : 3'b000;
    e_err    = (!rst && m_pv && m_perr) ? e_rvalid : 3'b000;
    e_rdata  = (!rst && m_pv) ? m_prdata : 32'd0;
  endtask

  // Evaluate expectations for the current inputs and move to the sample point
  task automatic cycle();
    compute_exp();
    @(negedge clk);
  endtask

  // Commit the current cycle into the model, then step past the clock edge
  task automatic advance();
    logic [31:0] a, old;
    int w;
    bit inr;
    compute_exp();
    if (rst) begin
      m_pv = 0; m_last_core = 0;
    end else if (e_win >= 0) begin
      a = addr[e_win]; w = int'(a[AW-1:2]); inr = (a < (32'd1 << AW));
      m_pv = 1; m_pidx = e_win; m_perr = !inr;
      m_prdata = (inr && !we[e_win]) ? ref_rd(w) : 32'd0;
      if (inr && we[e_win]) begin
        old = ref_rd(w);
        for (int b = 0; b < 4; b++)
          if (be[e_win][b]) old[8*b +: 8] = wdata[e_win][8*b +: 8];
        ref_mem[w] = old;
      end
      if (e_win != 0) m_last_core = e_win;
    end else begin
      m_pv = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    req = '0; addr = '0; we = '0; be = '0; wdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; set_idle(); cycle(); advance(); rst = 1'b0;
  endtask

  task automatic preload(int w, logic [31:0] v);
    pl_en = 1'b1; pl_addr = w[AW-3:0]; pl_data = v;
    @(posedge clk); #1;
    pl_en = 1'b0;
    ref_mem[w] = v;
  endtask

  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 9);
    logic [31:0] lo = 32'($urandom_range(0, 3));
    if (r == 0) return $urandom | (32'd1 << AW);
    if (r == 1) return 32'h003F_FFFC | lo;
    return (32'($urandom_range(0, 63)) << 2) | lo;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; req = 3'b111; addr = '0; we = '0; be = '1; wdata = '0;
    cycle();
    n_checks++; if (gnt_o !== 3'b000)   begin n_fail++; $display("FAIL reset_gnt: got %b expected 000", gnt_o); end
    n_checks++; if (ram_en !== 1'b0)    begin n_fail++; $display("FAIL reset_ram_en: got %b expected 0", ram_en); end
    n_checks++; if (rvalid_o !== 3'b000) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 000", rvalid_o); end
    n_checks++; if (err_o !== 3'b000)   begin n_fail++; $display("FAIL reset_err: got %b expected 000", err_o); end
    n_checks++; if (rdata_o !== 32'd0)  begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata_o); end
    advance();
    rst = 1'b0; set_idle();
  endtask

  task automatic test_single_read();
    do_reset();
    req = 3'b010; addr[1] = 32'h40; we[1] = 1'b0; be[1] = 4'hF;
    cycle();
    n_checks++; if (gnt_o !== 3'b010) begin n_fail++; $display("FAIL single_gnt: got %b expected 010", gnt_o); end
    n_checks++; if (ram_addr !== 20'h10) begin n_fail++; $display("FAIL single_ram_addr: got %h expected 10", ram_addr); end
    n_checks++; if (ram_en !== 1'b1) begin n_fail++; $display("FAIL single_ram_en: got %b expected 1", ram_en); end
    advance();
    set_idle(); cycle();
    n_checks++; if (rvalid_o !== 3'b010) begin n_fail++; $display("FAIL single_rvalid: got %b expected 010", rvalid_o); end
    n_checks++; if (rdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_rdata: got %h expected deadbeef", rdata_o); end
    n_checks++; if (err_o !== 3'b000) begin n_fail++; $display("FAIL single_err: got %b expected 000", err_o); end
    $display("txn single_read addr=00000040 rdata=%h", rdata_o);
    advance();
  endtask

  task automatic test_alternate();
    logic [2:0] prev = 3'b000;
    logic [2:0] exp_g;
    do_reset();
    req = 3'b110; addr[1] = 32'h4; addr[2] = 32'h8; we = '0; be = '1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      exp_g = (i % 2 == 0) ? 3'b010 : 3'b100;
      n_checks++; if (gnt_o !== exp_g) begin n_fail++; $display("FAIL alternate_gnt[%0d]: got %b expected %b", i, gnt_o, exp_g); end
      n_checks++; if (rvalid_o !== prev) begin n_fail++; $display("FAIL alternate_rvalid[%0d]: got %b expected %b", i, rvalid_o, prev); end
      $display("txn alternate cycle=%0d gnt=%b rvalid=%b", i, gnt_o, rvalid_o);
      prev = exp_g;
      advance();
    end
    set_idle(); cycle();
    n_checks++; if (rvalid_o !== prev) begin n_fail++; $display("FAIL alternate_last_rvalid: got %b expected %b", rvalid_o, prev); end
    advance();
  endtask

  task automatic test_loader_priority();
    do_reset();
    req = 3'b010; addr[1] = 32'h0; cycle();
    n_checks++; if (gnt_o !== 3'b010) begin n_fail++; $display("FAIL loader_pre_gnt: got %b expected 010", gnt_o); end
    advance();
    req = 3'b111; addr[0] = 32'h8; addr[2] = 32'hC;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++; if (gnt_o !== 3'b001) begin n_fail++; $display("FAIL loader_gnt[%0d]: got %b expected 001", i, gnt_o); end
      $display("txn loader cycle=%0d gnt=%b", i, gnt_o);
      advance();
    end
    req = 3'b110; cycle();
    n_checks++; if (gnt_o !== 3'b100) begin n_fail++; $display("FAIL loader_rr_kept: got %b expected 100", gnt_o); end
    advance();
    set_idle(); cycle(); advance();
  endtask

  task automatic test_out_of_range();
    do_reset();
    req = 3'b100; addr[2] = 32'h0040_0000; we[2] = 1'b0; be[2] = 4'hF;
    cycle();
    n_checks++; if (gnt_o !== 3'b100) begin n_fail++; $display("FAIL oor_gnt: got %b expected 100", gnt_o); end
    n_checks++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL oor_ram_en: got %b expected 0", ram_en); end
    advance();
    set_idle(); cycle();
    n_checks++; if (rvalid_o !== 3'b100) begin n_fail++; $display("FAIL oor_rvalid: got %b expected 100", rvalid_o); end
    n_checks++; if (err_o !== 3'b100) begin n_fail++; $display("FAIL oor_err: got %b expected 100", err_o); end
    n_checks++; if (rdata_o !== 32'd0) begin n_fail++; $display("FAIL oor_rdata: got %h expected 0", rdata_o); end
    $display("txn out_of_range addr=00400000 err=%b", err_o);
    advance();
  endtask

  task automatic test_write_then_read();
    do_reset();
    req = 3'b001; addr[0] = 32'h80; we[0] = 1'b1; be[0] = 4'b0011; wdata[0] = 32'h1234_5678;
    cycle();
    n_checks++; if (ram_be !== 4'b0011) begin n_fail++; $display("FAIL wr_ram_be: got %b expected 0011", ram_be); end
    n_checks++; if (ram_we !== 1'b1) begin n_fail++; $display("FAIL wr_ram_we: got %b expected 1", ram_we); end
    n_checks++; if (ram_wdata !== 32'h1234_5678) begin n_fail++; $display("FAIL wr_ram_wdata: got %h expected 12345678", ram_wdata); end
    advance();
    set_idle(); req = 3'b010; addr[1] = 32'h80; cycle();
    n_checks++; if (gnt_o !== 3'b010) begin n_fail++; $display("FAIL wr_rd_gnt: got %b expected 010", gnt_o); end
    n_checks++; if (rdata_o !== 32'd0 || rvalid_o !== 3'b001) begin n_fail++; $display("FAIL wr_resp: got rvalid=%b rdata=%h expected 001/0", rvalid_o, rdata_o); end
    advance();
    set_idle(); cycle();
    n_checks++; if (rdata_o !== 32'hAABB_5678) begin n_fail++; $display("FAIL wr_rd_rdata: got %h expected aabb5678", rdata_o); end
    $display("txn write_then_read rdata=%h", rdata_o);
    advance();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 3'b010; addr[1] = 32'h40; cycle();
    n_checks++; if (gnt_o !== 3'b010) begin n_fail++; $display("FAIL rstmid_gnt: got %b expected 010", gnt_o); end
    advance();
    rst = 1'b1; set_idle(); cycle();
    n_checks++; if (rvalid_o !== 3'b000 || rdata_o !== 32'd0) begin n_fail++; $display("FAIL rstmid_rvalid: got %b/%h expected 000/0", rvalid_o, rdata_o); end
    advance();
    rst = 1'b0; cycle();
    n_checks++; if (rvalid_o !== 3'b000) begin n_fail++; $display("FAIL rstmid_after: got %b expected 000", rvalid_o); end
    advance();
    req = 3'b110; addr[1] = 32'h4; addr[2] = 32'h8; cycle();
    n_checks++; if (gnt_o !== 3'b010) begin n_fail++; $display("FAIL rstmid_rr: got %b expected 010", gnt_o); end
    advance();
    set_idle(); cycle(); advance();
  endtask

  task automatic test_random();
    logic [2:0] last_gnt = 3'b000;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < 3; i++) begin
        if (req[i] && !last_gnt[i]) begin
          if ($urandom_range(0, 5) == 0) req[i] = 1'b0;
        end else begin
          req[i]   = (i == 0) ? ($urandom_range(0, 99) < 15) : ($urandom_range(0, 1) == 1);
          addr[i]  = rand_addr();
          we[i]    = 1'($urandom_range(0, 1));
          be[i]    = 4'($urandom_range(0, 15));
          wdata[i] = $urandom;
        end
      end
      cycle();
      n_checks++; if (gnt_o !== e_gnt) begin n_fail++; $display("FAIL rnd_gnt[%0d]: got %b expected %b", n, gnt_o, e_gnt); end
      n_checks++; if (ram_en !== e_ram_en) begin n_fail++; $display("FAIL rnd_ram_en[%0d]: got %b expected %b", n, ram_en, e_ram_en); end
      n_checks++; if ({ram_we, ram_addr, ram_be, ram_wdata} !== {e_ram_we, e_ram_addr, e_ram_be, e_ram_wdata}) begin
        n_fail++; $display("FAIL rnd_ram_bus[%0d]: got we=%b a=%h be=%b d=%h expected we=%b a=%h be=%b d=%h", n,
                           ram_we, ram_addr, ram_be, ram_wdata, e_ram_we, e_ram_addr, e_ram_be, e_ram_wdata);
      end
      n_checks++; if (rvalid_o !== e_rvalid) begin n_fail++; $display("FAIL rnd_rvalid[%0d]: got %b expected %b", n, rvalid_o, e_rvalid); end
      n_checks++; if (err_o !== e_err) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b expected %b", n, err_o, e_err); end
      n_checks++; if (rdata_o !== e_rdata) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %h expected %h", n, rdata_o, e_rdata); end
      if (e_win >= 0)
        $display("txn rnd cycle=%0d req=%0d addr=%h we=%b gnt=%b rvalid=%b", n, e_win, addr[e_win], we[e_win], gnt_o, rvalid_o);
      last_gnt = e_gnt;
      advance();
    end
    rst = 1'b0; set_idle(); cycle(); advance();
  endtask

  initial begin
    m_last_core = 0; m_pv = 0; m_pidx = 0; m_perr = 0; m_prdata = '0;
    rst = 1'b1; set_idle();
    @(posedge clk); #1;
    for (int w = 0; w < 64; w++) preload(w, $urandom);
    preload((1 << (AW-2)) - 1, $urandom);
    preload(32'h10, 32'hDEADBEEF);
    preload(32'h20, 32'hAABBCCDD);
    test_reset();
    test_single_read();
    test_alternate();
    test_loader_priority();
    test_out_of_range();
    test_write_then_read();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
